// File: rtl/osc_freq_meter.sv
// Clock-health monitor: counts rising edges of an asynchronous oscillator over a
// fixed gate window of system clocks and reports count, range and dead flags.
module osc_freq_meter #(
  parameter int              GATE_CYCLES = 50_000_000,
  parameter int              CNT_W       = 32,
  parameter int              SYNC_STAGES = 2,
  parameter logic [CNT_W-1:0] LO_LIMIT   = '0,
  parameter logic [CNT_W-1:0] HI_LIMIT   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             osc_in,
  output logic             busy,
  output logic             freq_valid,
  output logic [CNT_W-1:0] freq_cnt,
  output logic             freq_ok,
  output logic             osc_dead
);

  localparam int GATE_W = $clog2(GATE_CYCLES);
  localparam int ARM_W  = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {IDLE, ARM, GATE, LATCH} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic [ARM_W-1:0]       arm_cnt;
  logic [GATE_W-1:0]      gate_cnt;
  logic [CNT_W-1:0]       edge_cnt;
  logic                   rise;
  logic                   lo_ok;
  logic                   hi_ok;

  assign rise  = sync[SYNC_STAGES-1] & ~prev;
  assign hi_ok = (edge_cnt <= HI_LIMIT);

  // A zero lower limit is always met; skipping the compare avoids a constant test.
  if (LO_LIMIT == '0) begin : g_lo_none
    assign lo_ok = 1'b1;
  end else begin : g_lo_cmp
    assign lo_ok = (edge_cnt >= LO_LIMIT);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; the reset here is synchronous and covers every flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sync       <= '0;
      prev       <= 1'b0;
      arm_cnt    <= '0;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      busy       <= 1'b0;
      freq_valid <= 1'b0;
      freq_cnt   <= '0;
      freq_ok    <= 1'b0;
      osc_dead   <= 1'b0;
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], osc_in};
      prev       <= sync[SYNC_STAGES-1];
      freq_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (en) begin
            state   <= ARM;
            busy    <= 1'b1;
            arm_cnt <= '0;
          end
        end

        ARM: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          if (!en) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (arm_cnt == ARM_W'(SYNC_STAGES)) begin
            state <= GATE;
          end else begin
            arm_cnt <= arm_cnt + 1'b1;
          end
        end

        GATE: begin
          if (!en) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            // Saturate rather than wrap so an overfast input never reads as slow.
            if (rise && (edge_cnt != '1)) edge_cnt <= edge_cnt + 1'b1;
            if (gate_cnt == GATE_W'(GATE_CYCLES - 1)) state <= LATCH;
            else gate_cnt <= gate_cnt + 1'b1;
          end
        end

        LATCH: begin
          freq_valid <= 1'b1;
          freq_cnt   <= edge_cnt;
          freq_ok    <= lo_ok & hi_ok;
          osc_dead   <= (edge_cnt == '0);
          edge_cnt   <= '0;
          gate_cnt   <= '0;
          if (en) begin
            state <= GATE;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_osc_freq_meter.sv
// Scoreboard bench for osc_freq_meter: stimulus pushes expected results, per-DUT
// monitors pop and compare on every freq_valid pulse.
module tb_osc_freq_meter;

  logic        clk = 1'b0;
  logic        rst_a, en_a, rst_b, en_b, osc_in;
  logic        busy_a, valid_a, ok_a, dead_a;
  logic [31:0] cnt_a;
  logic        busy_b, valid_b, ok_b, dead_b;
  logic [3:0]  cnt_b;

  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          osc_period = 0;

  typedef struct {
    int unsigned lo;
    int unsigned hi;
    int unsigned at;
    bit          ok;
    bit          dead;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  osc_freq_meter #(
    .GATE_CYCLES(100), .CNT_W(32), .SYNC_STAGES(2),
    .LO_LIMIT(32'd20), .HI_LIMIT(32'd30)
  ) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .osc_in(osc_in),
    .busy(busy_a), .freq_valid(valid_a), .freq_cnt(cnt_a),
    .freq_ok(ok_a), .osc_dead(dead_a)
  );

  osc_freq_meter #(
    .GATE_CYCLES(100), .CNT_W(4), .SYNC_STAGES(2)
  ) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .osc_in(osc_in),
    .busy(busy_b), .freq_valid(valid_b), .freq_cnt(cnt_b),
    .freq_ok(ok_b), .osc_dead(dead_b)
  );

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_rng(input string name, input longint unsigned act,
                           input longint unsigned lo, input longint unsigned hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  // Oscillator model: high for ceil(p/2) clocks, low for the rest; p=0 holds low.
  initial begin
    int ph = 0;
    forever begin
      @(negedge clk);
      if (osc_period == 0) begin
        osc_in = 1'b0;
        ph     = 0;
      end else begin
        ph     = (ph + 1 >= osc_period) ? 0 : ph + 1;
        osc_in = (ph < (osc_period + 1) / 2);
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid_a) begin
        if (q_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected_valid: freq_valid=1 at cycle %0d, expected 0", cyc);
        end else begin
          e = q_a.pop_front();
          check("a_valid_cycle", cyc, e.at);
          check_rng("a_freq_cnt", cnt_a, e.lo, e.hi);
          check("a_freq_ok", ok_a, e.ok);
          check("a_osc_dead", dead_a, e.dead);
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid_b) begin
        if (q_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected_valid: freq_valid=1 at cycle %0d, expected 0", cyc);
        end else begin
          e = q_b.pop_front();
          check("b_valid_cycle", cyc, e.at);
          check_rng("b_freq_cnt", cnt_b, e.lo, e.hi);
          check("b_freq_ok", ok_b, e.ok);
          check("b_osc_dead", dead_b, e.dead);
        end
      end
    end
  end

  // Enable one DUT for n back-to-back windows, then drop en after the last result.
  task automatic measure(input bit sel, input int period, input int n,
                         input int unsigned lo, input int unsigned hi,
                         input bit ok, input bit dead);
    int unsigned k;
    exp_t        e;
    osc_period = period;
    repeat (6) @(negedge clk);
    k = cyc + 1;
    if (sel) en_b = 1'b1;
    else     en_a = 1'b1;
    for (int i = 0; i < n; i++) begin
      e.lo = lo; e.hi = hi; e.ok = ok; e.dead = dead;
      e.at = k + 104 + 101 * i;
      if (sel) q_b.push_back(e);
      else     q_a.push_back(e);
    end
    while (cyc < k + 104 + 101 * (n - 1)) @(negedge clk);
    if (sel) en_b = 1'b0;
    else     en_a = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish within 5000 cycles");
    $fatal(1);
  end

  initial begin
    int unsigned k;
    exp_t        e;
    rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b1; en_b = 1'b0; osc_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_cnt", cnt_a, 0);
    check("rst_ok", ok_a, 0);
    check("rst_dead", dead_a, 0);
    rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b0;
    repeat (3) @(negedge clk);

    // Period 4: 25 edges per 100-cycle window, two consecutive results.
    measure(1'b0, 4, 2, 25, 25, 1'b1, 1'b0);
    // Narrow counter: 25 edges saturate at 15.
    measure(1'b1, 4, 2, 15, 15, 1'b1, 1'b0);
    // Dead oscillator.
    measure(1'b0, 0, 1, 0, 0, 1'b0, 1'b1);
    // Range limits 20..30.
    measure(1'b0, 5, 1, 20, 20, 1'b1, 1'b0);
    measure(1'b0, 3, 1, 33, 34, 1'b0, 1'b0);

    // Abort in gate cycle 50 after a result of 25.
    osc_period = 4;
    repeat (6) @(negedge clk);
    k = cyc + 1;
    en_a = 1'b1;
    e.lo = 25; e.hi = 25; e.ok = 1'b1; e.dead = 1'b0; e.at = k + 104;
    q_a.push_back(e);
    while (cyc < k + 154) @(negedge clk);
    check("abort_busy_before", busy_a, 1);
    en_a = 1'b0;
    @(negedge clk);
    check("abort_busy", busy_a, 0);
    repeat (10) @(negedge clk);
    check("abort_cnt_hold", cnt_a, 25);
    check("abort_ok_hold", ok_a, 1);
    measure(1'b0, 4, 1, 25, 25, 1'b1, 1'b0);

    // Reset mid-window.
    osc_period = 4;
    repeat (3) @(negedge clk);
    k = cyc + 1;
    en_a = 1'b1;
    while (cyc < k + 50) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy_a, 0);
    check("midrst_valid", valid_a, 0);
    check("midrst_cnt", cnt_a, 0);
    check("midrst_ok", ok_a, 0);
    check("midrst_dead", dead_a, 0);
    rst_a = 1'b0;
    en_a  = 1'b0;
    repeat (150) @(negedge clk);

    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
